spi_sclk_gen: RTL and testbench

Parametrised SPI serial-clock generator, the successor to the free-running SPI clock-enable divider. It produces the SCLK waveform for a single framed transfer of a programmable bit count in any of the four CPOL/CPHA modes. It also emits per-edge sample/shift strobes and busy/done handshakes. It sits between the SPI master control FSM and the shift register feeding the rangefinder sensor interface.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_half_period_counter.sv | 29 ++
 rtl/spi_sclk_gen.sv | 159 +++++++++++++++
 tb/tb_spi_sclk_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator: FSM state encoding,
// SPI mode constants ({cpol,cpha}) and the bit-count helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        CLOCKING = 2'd2,
        HOLD     = 2'd3
    } spi_state_t;

    // SPI modes, encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Transfer length in bits from the programmed "bit count minus one"
    function automatic int unsigned xfer_bits(input int unsigned nbits);
        return nbits + 1;
    endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Programmable half-period divider. Counts 0..i_div and flags the terminal
// count; a divider of 0 produces a terminal count on every enabled cycle.
module spi_half_period_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_at_term;

    assign w_at_term = (r_cnt == i_div);
    assign o_tc      = i_enable && w_at_term;

    // Count up while enabled, wrap to zero at the terminal count
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator for one framed transfer of N bits in any
// CPOL/CPHA mode. A transfer is 2N+1 half-periods: SETUP, 2N-1 clocking
// half-periods, then a chip-select HOLD half-period. All outputs are
// registered; strobes coincide with the first cycle of the new sclk level.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int BIT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] divider,
    input  logic [BIT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             sample_en,
    output logic             shift_en,
    output logic             half_tick,
    output logic             busy,
    output logic             done
);

    // Edge numbers run up to 2*2^BIT_W, which needs one bit more than the
    // bit count itself plus one, so the edge counter never wraps.
    localparam int EDGE_W = BIT_W + 2;

    spi_state_t        r_state;
    logic [DIV_W-1:0]  r_div_l;
    logic [EDGE_W-1:0] r_last_edge;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_cpol_l;
    logic              r_cpha_l;

    logic              r_sclk;
    logic              r_sample;
    logic              r_shift;
    logic              r_half;
    logic              r_busy;
    logic              r_done;

    logic              w_tc;
    logic [EDGE_W-1:0] w_edge_num;
    logic              w_odd;
    logic              w_last;
    logic              w_sample;
    logic              w_shift;

    spi_half_period_counter #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == IDLE),
        .i_enable (r_state != IDLE),
        .i_div    (r_div_l),
        .o_tc     (w_tc)
    );

    // Number of the edge produced by the current terminal count (1..2N)
    assign w_edge_num = r_edge_cnt + EDGE_W'(1);
    assign w_odd      = w_edge_num[0];
    assign w_last     = (w_edge_num == r_last_edge);

    // Decode which strobe the upcoming edge carries for the latched mode
    always_comb begin
        w_sample = 1'b0;
        w_shift  = 1'b0;
        case ({r_cpol_l, r_cpha_l})
            MODE0, MODE2: begin
                // Leading edges sample; trailing edges shift, except the final
                // one since the first bit was preloaded at start.
                w_sample = w_odd;
                w_shift  = !w_odd && !w_last;
            end
            MODE1, MODE3: begin
                w_shift  = w_odd;
                w_sample = !w_odd;
            end
            default: begin
                w_sample = 1'b0;
                w_shift  = 1'b0;
            end
        endcase
    end

    // Transfer FSM with registered sclk, strobes and handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_div_l     <= '0;
            r_last_edge <= '0;
            r_edge_cnt  <= '0;
            r_cpol_l    <= 1'b0;
            r_cpha_l    <= 1'b0;
            r_sclk      <= 1'b0;
            r_sample    <= 1'b0;
            r_shift     <= 1'b0;
            r_half      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
            r_half   <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= cpol;
                    if (start && !abort) begin
                        r_div_l     <= divider;
                        r_last_edge <= EDGE_W'(2 * xfer_bits(32'(nbits)));
                        r_cpol_l    <= cpol;
                        r_cpha_l    <= cpha;
                        r_edge_cnt  <= '0;
                        r_state     <= SETUP;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_sclk  <= cpol;
                        r_busy  <= 1'b0;
                    end else if (w_tc) begin
                        r_half <= 1'b1;
                        if (r_state == HOLD) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_edge_cnt <= w_edge_num;
                            r_sample   <= w_sample;
                            r_shift    <= w_shift;
                            if (w_last) begin
                                r_sclk  <= r_cpol_l;
                                r_state <= HOLD;
                            end else begin
                                r_sclk  <= ~r_sclk;
                                r_state <= CLOCKING;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign sclk      = r_sclk;
    assign sample_en = r_sample;
    assign shift_en  = r_shift;
    assign half_tick = r_half;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen. A timeline model predicts every
// output cycle from the accepted transfer parameters; predictions are queued
// when stimulus is applied and popped when the DUT output is sampled.
// Per-transfer totals are checked from a second queue on each done pulse.
module tb_spi_sclk_gen;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] divider = '0;
    logic [4:0] nbits = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       sclk, sample_en, shift_en, half_tick, busy, done;

    spi_sclk_gen #(
        .DIV_W (8),
        .BIT_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .divider   (divider),
        .nbits     (nbits),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .sample_en (sample_en),
        .shift_en  (shift_en),
        .half_tick (half_tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cpol;
        bit cpha;
        int h;
        int n;
    } xfer_t;

    xfer_t      xfer_q[$];
    logic [5:0] exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_xfer = 0;

    // model state
    bit m_busy = 0;
    bit m_cpol, m_cpha;
    int m_c, m_h, m_n, m_b;

    // per-transfer observed totals
    int s_samp, s_shift, s_half, s_rise, s_fall;
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;
    bit   last_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pack(bit b, bit s, bit sa, bit sh, bit h, bit d);
        return {b, s, sa, sh, h, d};
    endfunction

    // Expected {busy,sclk,sample,shift,half,done} for cycle c of the transfer
    // (c=1 is the first busy cycle); edge k first shows at cycle k*H+1.
    function automatic logic [5:0] expect_at(int c);
        int  k;
        bit  at_edge, odd, samp, shft;
        if (c == m_b + 1) return pack(0, m_cpol, 0, 0, 1, 1);
        k       = (c - 1) / m_h;
        at_edge = (c > 1) && (((c - 1) % m_h) == 0);
        odd     = (k % 2) == 1;
        samp    = 0;
        shft    = 0;
        if (at_edge) begin
            samp = m_cpha ? !odd : odd;
            shft = m_cpha ? odd : (!odd && (k != 2 * m_n));
        end
        return pack(1, m_cpol ^ odd, samp, shft, at_edge, 0);
    endfunction

    // One clock: compare outputs at the falling edge, predict the next
    // cycle from the inputs about to be sampled, then step past the edge.
    task automatic tick();
        logic [5:0] e;
        xfer_t      x;
        @(negedge clk);
        last_done = (done === 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("cyc%0d", cyc), {26'd0, busy, sclk, sample_en, shift_en, half_tick, done}, {26'd0, e});
        end
        if (busy === 1'b1 && prev_busy === 1'b1 && sclk !== prev_sclk) begin
            if (sclk === 1'b1) s_rise++;
            else s_fall++;
        end
        prev_sclk = sclk;
        prev_busy = busy;
        if (sample_en === 1'b1) s_samp++;
        if (shift_en === 1'b1) s_shift++;
        if (half_tick === 1'b1) s_half++;
        if (last_done) begin
            if (xfer_q.size() == 0) begin
                chk("done_spurious", xfer_q.size(), 1);
            end else begin
                x = xfer_q.pop_front();
                n_xfer++;
                chk("n_sample", s_samp, x.n);
                chk("n_shift", s_shift, x.cpha ? x.n : x.n - 1);
                chk("n_half", s_half, 2 * x.n + 1);
                chk("n_rise", s_rise, x.n);
                chk("n_fall", s_fall, x.n);
                $display("xfer %0d cpol=%0d cpha=%0d H=%0d N=%0d samples=%0d shifts=%0d halves=%0d",
                         n_xfer, x.cpol, x.cpha, x.h, x.n, s_samp, s_shift, s_half);
            end
        end

        e = pack(0, cpol, 0, 0, 0, 0);
        if (reset) begin
            if (m_busy) void'(xfer_q.pop_back());
            m_busy = 0;
            e = '0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 0;
                void'(xfer_q.pop_back());
                $display("xfer aborted at cycle %0d of %0d", m_c, m_b);
            end else begin
                m_c++;
                e = expect_at(m_c);
                if (m_c == m_b + 1) m_busy = 0;
            end
        end else if (start && !abort) begin
            m_busy = 1;
            m_cpol = cpol;
            m_cpha = cpha;
            m_h    = int'(divider) + 1;
            m_n    = int'(nbits) + 1;
            m_b    = m_h * (2 * m_n + 1);
            m_c    = 1;
            e      = expect_at(1);
            xfer_q.push_back('{cpol: cpol, cpha: cpha, h: m_h, n: m_n});
            s_samp = 0; s_shift = 0; s_half = 0; s_rise = 0; s_fall = 0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        last_done = 0;
        while (!last_done && n < limit) begin
            tick();
            n++;
        end
        chk("done_wait", {31'd0, last_done}, 1);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input int div, input int nb);
        cpol    = mode[1];
        cpha    = mode[0];
        divider = 8'(div);
        nbits   = 5'(nb);
    endtask

    task automatic run(input logic [1:0] mode, input int div, input int nb, input int limit);
        set_cfg(mode, div, nb);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(limit);
    endtask

    initial begin
        // reset state
        ticks(3);
        reset = 1'b0;
        ticks(2);

        // mode 0, H=2, N=8
        run(MODE0, 1, 7, 100);
        ticks(3);

        // mode 3, H=1, N=1, idle level high beforehand
        set_cfg(MODE3, 0, 0);
        ticks(2);
        run(MODE3, 0, 0, 20);
        ticks(2);

        // longest transfer: N=32, H=256, edge counter must not wrap
        run(MODE0, 255, 31, 17000);
        ticks(2);

        // mode 2 aborted on its 10th busy cycle, restarted the next cycle
        set_cfg(MODE2, 3, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        ticks(2);

        // start held through a transfer while configuration changes
        set_cfg(MODE1, 3, 3);
        start = 1'b1;
        tick();
        ticks(5);
        set_cfg(MODE2, 0, 1);
        wait_done(200);
        start = 1'b0;
        wait_done(200);
        ticks(2);

        // reset in the middle of clocking with cpol=1
        set_cfg(MODE2, 1, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(3);

        // abort in idle, and abort together with start in idle
        abort = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        ticks(2);

        // abort in the final hold cycle outranks the terminal count
        set_cfg(MODE1, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ticks(3);

        // a handful of random short transfers
        for (int i = 0; i < 8; i++) begin
            run(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 5), 200);
            ticks($urandom_range(0, 2));
        end
        ticks(4);
        chk("xfer_q_left", xfer_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
